// File: rtl/credit_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : credit_arbiter
// Description : Round-robin packet arbiter for N_REQ AXI-Stream requesters
//               feeding a downstream buffer that is tracked with credits.
//               A grant is held for a whole packet, up to its tlast beat.
//               A beat moves only while at least one credit is free.
//               Each pop_i pulse returns one credit to the pool.
//
// Ports       : clk_i         clock, rising edge
//               rst_ni        asynchronous active-low reset
//               s_tvalid_i    per-requester valid            [N_REQ]
//               s_tdata_i     per-requester data             [N_REQ*DATA_W]
//               s_tlast_i     per-requester end-of-packet    [N_REQ]
//               s_tready_o    per-requester ready, one-hot or zero
//               m_tvalid_o    beat pushed downstream this cycle
//               m_tdata_o     pushed data, zero when nothing is pushed
//               m_tlast_o     pushed tlast, zero when nothing is pushed
//               pop_i         downstream consumed an entry; returns one credit
//               credit_o      free credits, 0..DEPTH
//               grant_o       current or most recent granted requester
//               busy_o        a packet is in progress
//               credit_err_o  sticky credit-overflow flag
//
// Options     : CREDIT_ARBITER_ERR_EN - when defined, credit_err_o sets on a
//               credit overflow and holds until reset. When undefined, the
//               flag logic is omitted and credit_err_o is tied to 0.
//               Credit saturation behaves the same in both builds.
//
// Revision    : 1.0 - initial release
// ============================================================================
module credit_arbiter #(
    parameter int N_REQ  = 4,
    parameter int DEPTH  = 10,
    parameter int DATA_W = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [N_REQ-1:0]             s_tvalid_i,
    input  logic [N_REQ*DATA_W-1:0]      s_tdata_i,
    input  logic [N_REQ-1:0]             s_tlast_i,
    output logic [N_REQ-1:0]             s_tready_o,
    output logic                         m_tvalid_o,
    output logic [DATA_W-1:0]            m_tdata_o,
    output logic                         m_tlast_o,
    input  logic                         pop_i,
    output logic [$clog2(DEPTH+1)-1:0]   credit_o,
    output logic [$clog2(N_REQ)-1:0]     grant_o,
    output logic                         busy_o,
    output logic                         credit_err_o
);

    localparam int c_credit_w = $clog2(DEPTH+1);
    localparam int c_grant_w  = $clog2(N_REQ);

    localparam logic [c_credit_w-1:0] c_depth    = c_credit_w'(DEPTH);
    localparam logic [c_grant_w-1:0]  c_last_req = c_grant_w'(N_REQ-1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t                  r_state;
    logic [c_credit_w-1:0]   r_credit;
    logic [c_grant_w-1:0]    r_grant;
    logic [c_grant_w-1:0]    r_rr_ptr;

    logic                    w_busy;
    logic                    w_credit_avail;
    logic                    w_credit_full;
    logic                    w_gnt_valid;
    logic                    w_gnt_last;
    logic [DATA_W-1:0]       w_gnt_data;
    logic                    w_fire;
    logic                    w_any_valid;
    logic                    w_found;
    logic [c_grant_w-1:0]    w_cand;
    logic [c_grant_w-1:0]    w_sel;
    logic [c_grant_w-1:0]    w_next_ptr;
    logic [c_credit_w-1:0]   w_credit_next;

    assign w_busy         = (r_state == S_BUSY);
    assign w_credit_avail = (r_credit != '0);
    assign w_credit_full  = (r_credit == c_depth);

    // Pick out the granted requester's stream signals.
    always_comb begin
        w_gnt_valid = 1'b0;
        w_gnt_last  = 1'b0;
        w_gnt_data  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (r_grant == c_grant_w'(k)) begin
                w_gnt_valid = s_tvalid_i[k];
                w_gnt_last  = s_tlast_i[k];
                w_gnt_data  = s_tdata_i[k*DATA_W +: DATA_W];
            end
        end
    end

    assign w_fire = w_busy & w_gnt_valid & w_credit_avail;

    // Round-robin search: walk the requesters starting at r_rr_ptr and take
    // the first one that has a valid beat.
    always_comb begin
        w_any_valid = |s_tvalid_i;
        w_found     = 1'b0;
        w_sel       = r_rr_ptr;
        w_cand      = r_rr_ptr;
        for (int i = 0; i < N_REQ; i++) begin
            w_cand = c_grant_w'((int'(r_rr_ptr) + i) % N_REQ);
            if (!w_found && s_tvalid_i[w_cand]) begin
                w_found = 1'b1;
                w_sel   = w_cand;
            end
        end
    end

    assign w_next_ptr = (r_grant == c_last_req) ? '0 : r_grant + 1'b1;

    // When a fire and a pop happen in the same cycle, they cancel out. A
    // return with no fire while the pool is full saturates at DEPTH.
    always_comb begin
        w_credit_next = r_credit;
        case ({w_fire, pop_i})
            2'b10:   w_credit_next = r_credit - 1'b1;
            2'b01:   w_credit_next = w_credit_full ? r_credit : r_credit + 1'b1;
            default: w_credit_next = r_credit;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= S_IDLE;
            r_credit <= c_depth;
            r_grant  <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_credit <= w_credit_next;
            case (r_state)
                S_IDLE: begin
                    // Arbitration takes one cycle, and no beat moves in IDLE.
                    if (w_any_valid) begin
                        r_grant <= w_sel;
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    // The grant stays locked until the tlast beat transfers.
                    if (w_fire && w_gnt_last) begin
                        r_rr_ptr <= w_next_ptr;
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef CREDIT_ARBITER_ERR_EN
    logic w_overflow;
    logic r_credit_err;

    assign w_overflow = pop_i & ~w_fire & w_credit_full;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_credit_err <= 1'b0;
        end else if (w_overflow) begin
            r_credit_err <= 1'b1;
        end
    end

    assign credit_err_o = r_credit_err;
`else
    assign credit_err_o = 1'b0;
`endif

    // Only the granted requester can see ready, and only when a credit is free.
    generate
        for (genvar k = 0; k < N_REQ; k++) begin : g_ready
            assign s_tready_o[k] = w_busy & w_credit_avail & (r_grant == c_grant_w'(k));
        end
    endgenerate

    assign m_tvalid_o = w_fire;
    assign m_tdata_o  = w_fire ? w_gnt_data : '0;
    assign m_tlast_o  = w_fire & w_gnt_last;
    assign credit_o   = r_credit;
    assign grant_o    = r_grant;
    assign busy_o     = w_busy;

endmodule
`default_nettype wire

// File: doc/credit_arbiter.md
CREDIT_ARBITER -- requirements
Module: credit_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of AXI-Stream requesters (2..8).
REQ-002 Parameter DEPTH, default 10, downstream buffer depth = initial credit count.
REQ-003 Parameter DATA_W, default 8, tdata width per requester.
REQ-004 clk_i  input  1  single clock; all logic on rising edge.
REQ-005 rst_ni  input  1  asynchronous, active-low reset.
REQ-006 s_tvalid_i  input  N_REQ  per-requester valid.
REQ-007 s_tdata_i  input  N_REQ*DATA_W  per-requester data, requester k at bits [k*DATA_W +: DATA_W].
REQ-008 s_tlast_i  input  N_REQ  per-requester end-of-packet.
REQ-009 s_tready_o  output  N_REQ  per-requester ready; at most one bit high.
REQ-010 m_tvalid_o  output  1  beat pushed into downstream buffer this cycle.
REQ-011 m_tdata_o  output  DATA_W  pushed data.
REQ-012 m_tlast_o  output  1  pushed tlast.
REQ-013 pop_i  input  1  downstream buffer consumed one entry; returns one credit.
REQ-014 credit_o  output  $clog2(DEPTH+1)  current free credits.
REQ-015 grant_o  output  $clog2(N_REQ)  index of current/last granted requester.
REQ-016 busy_o  output  1  FSM in BUSY.
REQ-017 credit_err_o  output  1  sticky credit overflow flag (see Configuration).

Function
REQ-018 FSM states IDLE, BUSY; single state register.
REQ-019 IDLE: if any s_tvalid_i high, select first requester with valid at or after rr_ptr (round-robin, wrapping N_REQ-1 -> 0), load grant_o, go BUSY next cycle; no transfer in IDLE.
REQ-020 IDLE with no valid: stay IDLE, grant_o holds.
REQ-021 BUSY: s_tready_o[grant] = (credit_o != 0); all other ready bits 0.
REQ-022 Fire = BUSY and s_tvalid_i[grant] and credit_o != 0; m_tvalid_o = fire, m_tdata_o/m_tlast_o = granted requester's tdata/tlast (combinational, zero latency).
REQ-023 m_tdata_o and m_tlast_o driven 0 when not fire.
REQ-024 Fire with s_tlast_i[grant]=1: next state IDLE, rr_ptr = grant+1 modulo N_REQ.
REQ-025 Grant locked for whole packet; other requests ignored until tlast beat fires.
REQ-026 credit_o: fire only -> minus 1; pop_i only -> plus 1; fire and pop_i same cycle -> unchanged.
REQ-027 credit_o == 0: no fire, granted requester stalls, FSM stays BUSY; pop_i that cycle enables fire next cycle.
REQ-028 pop_i with credit_o == DEPTH and no fire: credit_o saturates at DEPTH; overflow event.
REQ-029 Throughput: one beat per cycle in BUSY with credit available; 1 idle cycle between packets (arbitration).

Reset
REQ-030 rst_ni low asynchronously forces: state IDLE, credit_o = DEPTH, rr_ptr = 0, grant_o = 0, credit_err_o = 0, s_tready_o = 0, m_tvalid_o = 0.
REQ-031 Reset mid-packet drops the packet; no partial-packet recovery; outputs valid reset values while rst_ni low.

Configuration
REQ-032 Macro CREDIT_ARBITER_ERR_EN defined: credit_err_o sets on any overflow event (REQ-028), held until reset.
REQ-033 Macro undefined: overflow logic omitted, credit_err_o tied 0; saturation per REQ-028 unchanged.

Verification
REQ-034 Reset release, requester 0 sends 3-beat packet, no pop_i -> IDLE 1 cycle, 3 fires on consecutive cycles, credit_o 10->7, FSM IDLE, rr_ptr=1.
REQ-035 All 4 requesters hold 1-beat packets continuously -> grants 0,1,2,3,0 in order, one packet per 2 cycles.
REQ-036 Requester 2 sends 12-beat packet, pop_i idle -> 10 fires, credit_o=0, s_tready_o[2]=0 stall; single pop_i pulse -> exactly 1 further beat next cycle.
REQ-037 credit_o=5, fire and pop_i in same cycle -> credit_o stays 5.
REQ-038 Idle, credit_o=10, pop_i pulse -> credit_o stays 10; credit_err_o=1 with CREDIT_ARBITER_ERR_EN, 0 without.
REQ-039 Requester 1 mid-packet (beat 2 of 4), rst_ni low 1 cycle -> immediate IDLE, credit_o=10, all ready 0, grant_o=0.
